// File: rtl/mux8to1_rr_pkg.sv
// Shared definitions for the 8-channel round-robin registered multiplexer.
//   NumCh   : number of channels (8)
//   IdxW    : width of a channel index (3)
//   state_e : controller state, IDLE (no word held) / HOLD (word presented)
//   onehot8 : decode a channel index to an 8-bit one-hot vector
package mux8to1_rr_pkg;

  localparam int unsigned NumCh = 8;
  localparam int unsigned IdxW  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [NumCh-1:0] onehot8(input logic [IdxW-1:0] idx);
    logic [NumCh-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux8to1_rr_pick8.sv
// rr_pick8: round-robin index search over an 8-bit request vector.
// Returns the first set bit scanning upward from ptr+1 (modulo 8); ptr itself
// is examined last, so the most recently served channel has lowest priority.
// Ports:
//   vec   : candidate request vector
//   ptr   : index of the most recently granted channel
//   idx   : selected channel (equals ptr when nothing is found)
//   found : at least one bit of vec is set
module rr_pick8
  import mux8to1_rr_pkg::*;
(
  input  logic [NumCh-1:0] vec,
  input  logic [IdxW-1:0]  ptr,
  output logic [IdxW-1:0]  idx,
  output logic             found
);

  logic [IdxW-1:0] cand;

  // Walk offsets from farthest to nearest; the nearest hit is written last and wins.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = NumCh; k >= 1; k--) begin
      cand = ptr + IdxW'(k);
      if (vec[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8to1_rr.sv
// mux8to1_rr: 8-to-1 round-robin multiplexer with a registered output word
// and a valid/ready handshake.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   enable  : permits new grants (an in-flight word is always completed)
//   req     : per-channel request lines
//   din     : channel data, channel i at din[i*DW +: DW]
//   ready   : downstream accepts the presented word
//   sel_out : granted channel index (registered)
//   dout    : captured data of the granted channel (registered)
//   valid   : sel_out/dout hold a word
//   ack     : one-hot acknowledge to the served channel on a handshake (combinational)
//   err     : sticky flag, set when a grant considers more than one request
// Build option: define MUX8_ONEHOT_CHK_EN to include the multi-request checker;
// otherwise err is tied to 0.
module mux8to1_rr
  import mux8to1_rr_pkg::*;
#(
  parameter int unsigned DW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [NumCh-1:0]    req,
  input  logic [NumCh*DW-1:0] din,
  input  logic                ready,
  output logic [IdxW-1:0]     sel_out,
  output logic [DW-1:0]       dout,
  output logic                valid,
  output logic [NumCh-1:0]    ack,
  output logic                err
);

  state_e          state_q;
  logic [IdxW-1:0] sel_q;
  logic [IdxW-1:0] ptr_q;
  logic [DW-1:0]   dout_q;

  logic [NumCh-1:0] cand_vec;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_found;
  logic             grant;

  // On a handshake the channel just served is masked out so a persistent
  // requester cannot be re-granted back-to-back ahead of others.
  always_comb begin
    cand_vec = req;
    if (state_q == HOLD) begin
      cand_vec = req & ~onehot8(sel_q);
    end
  end

  rr_pick8 u_pick (
    .vec   (cand_vec),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign grant = enable && pick_found && ((state_q == IDLE) || ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      dout_q  <= '0;
      ptr_q   <= IdxW'(NumCh - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q <= HOLD;
            sel_q   <= pick_idx;
            dout_q  <= din[DW*int'(pick_idx) +: DW];
            ptr_q   <= pick_idx;
          end
        end
        HOLD: begin
          if (ready) begin
            if (grant) begin
              sel_q  <= pick_idx;
              dout_q <= din[DW*int'(pick_idx) +: DW];
              ptr_q  <= pick_idx;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid   = (state_q == HOLD);
  assign sel_out = sel_q;
  assign dout    = dout_q;
  assign ack     = (valid && ready) ? onehot8(sel_q) : '0;

`ifdef MUX8_ONEHOT_CHK_EN
  logic err_q;
  logic multi_req;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_req = |(cand_vec & (cand_vec - NumCh'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (grant && multi_req) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux8to1_rr.sv
// Self-checking bench for mux8to1_rr: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level round-robin model.
module tb_mux8to1_rr;

  localparam int unsigned DW = 8;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          enable = 1'b0;
  logic          ready  = 1'b0;
  logic [7:0]    req    = 8'h00;
  logic [8*DW-1:0] din  = '0;
  logic [2:0]    sel_out;
  logic [DW-1:0] dout;
  logic          valid;
  logic [7:0]    ack;
  logic          err;

  int n_cmp = 0;
  int n_err = 0;

  mux8to1_rr #(.DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .req     (req),
    .din     (din),
    .ready   (ready),
    .sel_out (sel_out),
    .dout    (dout),
    .valid   (valid),
    .ack     (ack),
    .err     (err)
  );

  always #5 clk = ~clk;

`ifdef MUX8_ONEHOT_CHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  // Reference model state
  bit            m_valid = 1'b0;
  int            m_sel   = 0;
  int            m_ptr   = 7;
  logic [DW-1:0] m_dout  = '0;
  bit            m_err   = 1'b0;
  logic [7:0]    m_vec;
  bit            m_consider;
  int            m_g;

  function automatic int rr_next(input logic [7:0] v, input int p);
    for (int k = 1; k <= 8; k++) begin
      if (v[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_sel   = 0;
      m_ptr   = 7;
      m_dout  = '0;
      m_err   = 1'b0;
    end else begin
      m_consider = 1'b0;
      m_vec      = req;
      if (!m_valid) begin
        m_consider = 1'b1;
      end else if (ready) begin
        m_vec      = req & ~(8'd1 << m_sel);
        m_consider = 1'b1;
      end
      if (m_consider) begin
        m_g = rr_next(m_vec, m_ptr);
        if (enable && m_g >= 0) begin
          m_sel   = m_g;
          m_ptr   = m_g;
          m_dout  = din[m_g*DW +: DW];
          m_valid = 1'b1;
          if (ChkEn && $countones(m_vec) > 1) m_err = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("valid", {63'd0, valid}, {63'd0, m_valid});
    check("sel_out", {61'd0, sel_out}, 64'(m_sel));
    check("dout", {56'd0, dout}, {56'd0, m_dout});
    check("ack", {56'd0, ack}, (m_valid && ready) ? 64'(8'd1 << m_sel) : 64'd0);
    check("err", {63'd0, err}, {63'd0, m_err});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    req   = 8'h00;
    ready = 1'b0;
    rst   = 1'b1;
    cyc();
    rst   = 1'b0;
  endtask

  initial begin
    repeat (2) cyc();
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_sel", {61'd0, sel_out}, 64'd0);
    check("rst_dout", {56'd0, dout}, 64'd0);
    check("rst_ack", {56'd0, ack}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);

    // Single request on channel 4, one-cycle latency
    rst    = 1'b0;
    enable = 1'b1;
    req    = 8'h10;
    din    = '0;
    din[4*DW +: DW] = 8'h01;
    ready  = 1'b1;
    cyc();
    check("ch4_valid", {63'd0, valid}, 64'd1);
    check("ch4_sel", {61'd0, sel_out}, 64'd4);
    check("ch4_dout", {56'd0, dout}, 64'd1);
    check("ch4_ack", {56'd0, ack}, 64'h10);
    req = 8'h00;
    cyc();
    check("ch4_done", {63'd0, valid}, 64'd0);

    // Two persistent requesters alternate back-to-back
    do_reset();
    req   = 8'h81;
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("alt_sel", {61'd0, sel_out}, (i % 2 == 0) ? 64'd0 : 64'd7);
      check("alt_valid", {63'd0, valid}, 64'd1);
    end

    // Stall: word held while din/req churn
    do_reset();
    din = '0;
    din[2*DW +: DW] = 8'hAB;
    req   = 8'h04;
    ready = 1'b0;
    cyc();
    check("hold_sel0", {61'd0, sel_out}, 64'd2);
    check("hold_dout0", {56'd0, dout}, 64'hAB);
    for (int i = 0; i < 5; i++) begin
      din = {$urandom, $urandom};
      req = 8'($urandom);
      cyc();
      check("hold_sel", {61'd0, sel_out}, 64'd2);
      check("hold_dout", {56'd0, dout}, 64'hAB);
      check("hold_ack", {56'd0, ack}, 64'd0);
    end

    // Single requester: exactly one transfer, no double grant
    req   = 8'h04;
    ready = 1'b1;
    #1;
    check("one_ack", {56'd0, ack}, 64'h04);
    cyc();
    check("one_after", {63'd0, valid}, 64'd0);
    req = 8'h00;
    cyc();
    check("one_idle", {63'd0, valid}, 64'd0);

    // Reset in flight discards the word, then channel 0 wins first
    req   = 8'h08;
    ready = 1'b0;
    cyc();
    check("rf_sel", {61'd0, sel_out}, 64'd3);
    ready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("rf_valid", {63'd0, valid}, 64'd0);
    check("rf_sel0", {61'd0, sel_out}, 64'd0);
    check("rf_ack", {56'd0, ack}, 64'd0);
    cyc();
    rst   = 1'b0;
    req   = 8'hFF;
    ready = 1'b0;
    cyc();
    check("rf_first", {61'd0, sel_out}, 64'd0);
    check("rf_fvalid", {63'd0, valid}, 64'd1);

    // Multi-request flag is sticky through one-hot traffic
    do_reset();
    req   = 8'h03;
    ready = 1'b1;
    cyc();
    check("err_set", {63'd0, err}, {63'd0, ChkEn});
    req = 8'h20;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("err_stay", {63'd0, err}, {63'd0, ChkEn});
    end
    do_reset();
    cyc();
    check("err_clr", {63'd0, err}, 64'd0);

    // Randomized traffic, checked every cycle by the model compare
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 7) != 0);
      ready  = ($urandom_range(0, 2) != 0);
      req    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      din    = {$urandom, $urandom};
      rst    = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux8to1_rr.md
MUX8TO1_RR -- requirements
Module: mux8to1_rr

Interface
REQ-001 The block SHALL have a parameter DW, default 1, giving the data width per channel in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port enable, input, 1 bit: permits new grants.
REQ-005 The block SHALL have port req, input, 8 bits: per-channel request lines; bit i is channel i.
REQ-006 The block SHALL have port din, input, 8*DW bits: channel data; channel i occupies din[i*DW +: DW].
REQ-007 The block SHALL have port ready, input, 1 bit: the downstream consumer accepts the presented word.
REQ-008 The block SHALL have port sel_out, output, 3 bits: index of the granted channel (registered).
REQ-009 The block SHALL have port dout, output, DW bits: the captured data of the granted channel (registered).
REQ-010 The block SHALL have port valid, output, 1 bit: sel_out and dout are valid.
REQ-011 The block SHALL have port ack, output, 8 bits: one-hot acknowledge to the served channel, combinational.
REQ-012 The block SHALL have port err, output, 1 bit: sticky multi-request flag (see Configuration).

Function
REQ-013 The block SHALL implement a two-state FSM with states IDLE (valid=0) and HOLD (valid=1).
REQ-014 In IDLE, with enable=1 and req!=0, the block SHALL:
- pick grant g as the first set req bit, scanning upward from ptr+1 modulo 8;
- at that edge, load sel_out=g, dout=din slice g, ptr=g;
- go to HOLD.
- Latency is 1 cycle from req sampled to valid=1.
REQ-015 In IDLE, with enable=0 or req=0, the block SHALL remain in IDLE with all registers held.
REQ-016 In HOLD, sel_out and dout SHALL stay stable until ready=1; changes on din or req SHALL be ignored.
REQ-017 ack SHALL equal the one-hot decode of sel_out when valid&&ready, and 8'h00 otherwise.
REQ-018 On a handshake edge (valid&&ready), with enable=1 and (req & ~onehot(sel_out))!=0, the block SHALL reload the next round-robin grant over that masked vector and stay in HOLD, giving back-to-back transfers.
REQ-019 On a handshake edge otherwise, the block SHALL return to IDLE with valid=0.
REQ-020 Wrap-around: ptr=7 SHALL search from channel 0.
REQ-021 A channel re-requesting after service SHALL wait behind all other pending channels.
REQ-022 enable falling while in HOLD SHALL NOT abort the current transfer; only the reload SHALL be suppressed.

Reset
REQ-023 While rst=1, the block SHALL asynchronously force: state=IDLE, valid=0, sel_out=0, dout=0, ptr=7, err=0; ack is therefore 0.
REQ-024 Reset asserted mid-HOLD SHALL discard the pending word with no ack.
REQ-025 After rst deasserts, the first grant SHALL favour channel 0.

Configuration
REQ-026 When macro MUX8_ONEHOT_CHK_EN is defined, err SHALL set on any grant edge where the considered request vector has more than one bit set, and SHALL clear only on rst; arbitration SHALL be unaffected.
REQ-027 When MUX8_ONEHOT_CHK_EN is undefined, err SHALL be constant 0 and no checker logic SHALL be present.

Structure
REQ-028 A shared package SHALL hold: the channel count (8), the index width (3), the FSM state type {IDLE, HOLD}, and a one-hot decode function.
REQ-029 The round-robin next-index search SHALL be one sub-module, rr_pick8 (inputs: 8-bit vector, 3-bit ptr; outputs: 3-bit index, found).

Verification
REQ-030 Reset, then req=8'h10, din slice4=1, ready=1 → valid=1 one cycle later with sel_out=4 and dout=1; ack=8'h10 in that cycle.
REQ-031 req=8'h81 held, ready=1 continuously, masked reload → sel_out sequence 0,7,0,7…; valid stays 1 throughout.
REQ-032 Grant channel 2, ready=0 for 5 cycles while din and req change → sel_out=2 and dout unchanged for 5 cycles; ack=0.
REQ-033 req=8'h04 only, ready=1, requester drops req after ack → one transfer, then valid=0 (no double grant).
REQ-034 Grant in flight, assert rst → valid=0, sel_out=0 immediately; no ack. Then req=8'hFF → first sel_out=0.
REQ-035 With MUX8_ONEHOT_CHK_EN defined: req=8'h03 → err=1 and stays 1 through later one-hot traffic until rst. Without the macro: err=0.
